// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use, multi-cycle double ops, taken branches.
// Optional HAZARD_STATS_EN adds saturating stall_cycles / flush_events counters.
module pipe_hazard_ctrl #(
  parameter int DBL_LAT = 3,
  parameter int REG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs_D,
  input  logic [REG_W-1:0] rt_D,
  input  logic             uses_rt_D,
  input  logic [REG_W-1:0] writereg_X,
  input  logic             memread_X,
  input  logic             regwrite_X,
  input  logic             double_X,
  input  logic             branch_taken_X,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_X,
  output logic             flush_D,
  output logic             flush_X,
  output logic             bubble_M,
  output logic             busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_events
`endif
);

  typedef enum logic {IDLE, DBL_BUSY} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(DBL_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu;

  assign lu = memread_X & regwrite_X & (writereg_X != '0) &
              ((writereg_X == rs_D) | (uses_rt_D & (writereg_X == rt_D)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_X  = 1'b0;
    flush_D  = 1'b0;
    flush_X  = 1'b0;
    bubble_M = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A taken branch squashes the D instruction, so its load-use hazard is moot.
        if (branch_taken_X) begin
          flush_D = 1'b1;
          flush_X = 1'b1;
        end else if (double_X && (DBL_LAT > 1)) begin
          stall_F  = 1'b1;
          stall_D  = 1'b1;
          stall_X  = 1'b1;
          bubble_M = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = DBL_BUSY;
        end else if (lu) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          flush_X = 1'b1;
        end
      end
      DBL_BUSY: begin
        // X inputs are frozen while ID/EX is held, so branch and lu are not evaluated here.
        busy = 1'b1;
        if (cnt_q > 4'd1) begin
          stall_F  = 1'b1;
          stall_D  = 1'b1;
          stall_X  = 1'b1;
          bubble_M = 1'b1;
          cnt_d    = cnt_q - 4'd1;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_events_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (stall_F && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_D && (flush_events_q != '1)) flush_events_q <= flush_events_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (DBL_LAT=3); checks stats ports when HAZARD_STATS_EN is defined.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_D, rt_D, writereg_X;
  logic       uses_rt_D, memread_X, regwrite_X, double_X, branch_taken_X;
  logic       stall_F, stall_D, stall_X, flush_D, flush_X, bubble_M, busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_events;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DBL_LAT(3), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_D(rs_D), .rt_D(rt_D), .uses_rt_D(uses_rt_D),
    .writereg_X(writereg_X), .memread_X(memread_X), .regwrite_X(regwrite_X),
    .double_X(double_X), .branch_taken_X(branch_taken_X),
    .stall_F(stall_F), .stall_D(stall_D), .stall_X(stall_X),
    .flush_D(flush_D), .flush_X(flush_X), .bubble_M(bubble_M), .busy(busy)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  // Expected output packing: {stall_F, stall_D, stall_X, flush_D, flush_X, bubble_M, busy}
  localparam logic [6:0] O_NONE   = 7'b0000000;
  localparam logic [6:0] O_LU     = 7'b1100100;
  localparam logic [6:0] O_BR     = 7'b0001100;
  localparam logic [6:0] O_DBL0   = 7'b1110010;
  localparam logic [6:0] O_DBLB   = 7'b1110011;
  localparam logic [6:0] O_DBLEND = 7'b0000001;

  typedef struct {
    logic [4:0] rs, rt, wr;
    logic       urt, mr, rw, dbl, br;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                              input logic [4:0] wr, input logic mr, input logic rw,
                              input logic br, input logic [6:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urt = urt; v.wr = wr; v.mr = mr; v.rw = rw;
    v.dbl = 1'b0; v.br = br; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rs_D = v.rs; rt_D = v.rt; uses_rt_D = v.urt; writereg_X = v.wr;
    memread_X = v.mr; regwrite_X = v.rw; double_X = v.dbl; branch_taken_X = v.br;
  endtask

  task automatic quiet();
    rs_D = '0; rt_D = '0; uses_rt_D = 1'b0; writereg_X = '0;
    memread_X = 1'b0; regwrite_X = 1'b0; double_X = 1'b0; branch_taken_X = 1'b0;
  endtask

  // Compare mid-cycle, then advance to just after the next rising edge.
  task automatic cyc_check(input string name, input logic [6:0] exp);
    logic [6:0] got;
    #3;
    got = {stall_F, stall_D, stall_X, flush_D, flush_X, bubble_M, busy};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end else begin
      $display("[TB] ok   %s: %b", name, got);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    quiet();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = mk(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, O_LU);   // load-use on rs
    vecs[1] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE); // load moved on
    vecs[2] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, O_NONE); // $zero ignored
    vecs[3] = mk(5'd3, 5'd9, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, O_NONE); // rt not read
    vecs[4] = mk(5'd3, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, O_LU);   // load-use on rt
    vecs[5] = mk(5'd8, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0, O_NONE); // not a load
    vecs[6] = mk(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, O_NONE); // no regwrite
    vecs[7] = mk(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, O_BR);   // branch beats lu
    vecs[8] = mk(5'd1, 5'd2, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, O_BR);   // plain branch
    vecs[9] = mk(5'd8, 5'd8, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, O_NONE); // register mismatch

    rst_n = 1'b0;
    quiet();
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc_check("reset_state", O_NONE);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i]);
      cyc_check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Double op, DBL_LAT=3; a branch during DBL_BUSY must be ignored.
    do_reset();
    double_X = 1'b1;
    cyc_check("dbl_c0", O_DBL0);
    branch_taken_X = 1'b1;
    cyc_check("dbl_c1", O_DBLB);
    branch_taken_X = 1'b0;
    cyc_check("dbl_c2", O_DBLEND);
    double_X = 1'b0;
    cyc_check("dbl_c3", O_NONE);

    // Reset while in DBL_BUSY.
    double_X = 1'b1;
    cyc_check("rst_c0", O_DBL0);
    rst_n = 1'b0;
    cyc_check("rst_c1", O_DBLB);
    rst_n = 1'b1;
    double_X = 1'b0;
    cyc_check("rst_c2", O_NONE);

    // LDC1-type: load that is also a double takes the double path, no extra lu stall afterwards.
    rs_D = 5'd8; writereg_X = 5'd8; memread_X = 1'b1; regwrite_X = 1'b1; double_X = 1'b1;
    cyc_check("ldc1_c0", O_DBL0);
    cyc_check("ldc1_c1", O_DBLB);
    cyc_check("ldc1_c2", O_DBLEND);
    quiet();
    cyc_check("ldc1_c3", O_NONE);

`ifdef HAZARD_STATS_EN
    do_reset();
    drive(vecs[0]);
    cyc_check("st_lu", O_LU);
    drive(vecs[7]);
    cyc_check("st_br", O_BR);
    quiet();
    double_X = 1'b1;
    cyc_check("st_d0", O_DBL0);
    cyc_check("st_d1", O_DBLB);
    cyc_check("st_d2", O_DBLEND);
    double_X = 1'b0;
    #3;
    n_tests++;
    if (stall_cycles !== 32'd3) begin
      n_fail++;
      $display("[TB] FAIL stall_cycles: got %0d expected 3", stall_cycles);
    end
    n_tests++;
    if (flush_events !== 16'd1) begin
      n_fail++;
      $display("[TB] FAIL flush_events: got %0d expected 1", flush_events);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
